// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// stage record layout, Tuse/Tnew timing constants and forward-select codes.
package hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_ID   = 2'd0;
    localparam logic [1:0] TUSE_EX   = 2'd1;
    localparam logic [1:0] TUSE_MEM  = 2'd2;

    localparam logic [1:0] TNEW_LW   = 2'd2;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_NONE = 2'd0;

    // ID-stage compare operand selects
    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;

    // EX ALU operand selects (different encoding from the ID selects)
    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EX_M  = 2'd1;
    localparam logic [1:0] FWD_W     = 2'd2;

    typedef struct packed {
        logic [4:0] dst;
        logic       we;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       store;
    } stage_rec_t;

    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Register 0 and non-writing stages never produce a value.
    function automatic logic producer_match(input stage_rec_t r, input logic [4:0] src);
        return (src != 5'd0) && r.we && (r.dst != 5'd0) && (r.dst == src);
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage record for the hazard controller, with bubble
// insertion and asynchronous clear.
module hazard_stage_reg
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       bubble,
    input  stage_rec_t d,
    output stage_rec_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: tracks writers in E/M/W,
// stalls on unforwardable hazards and drives the forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_we,
    input  logic             id_lw,
    input  logic             id_link,
    input  logic             id_b_type,
    input  logic             id_jr,
    input  logic             id_store,
    output logic             stall,
    output logic [1:0]       fwd_id_rs,
    output logic [1:0]       fwd_id_rt,
    output logic [1:0]       fwd_ex_rs,
    output logic [1:0]       fwd_ex_rt,
    output logic             fwd_mem_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_rec_t id_rec, e_rec, m_rec, w_rec;
    stage_rec_t m_next, w_next;
    logic [1:0] tuse_rs, tuse_rt;
    logic       unused_bits;

    always_comb begin
        id_rec       = '0;
        id_rec.dst   = id_dst;
        id_rec.we    = id_we;
        id_rec.rs    = id_rs;
        id_rec.rt    = id_rt;
        id_rec.store = id_store;
        if (!id_we)       id_rec.tnew = TNEW_NONE;
        else if (id_link) id_rec.tnew = TNEW_LINK;
        else if (id_lw)   id_rec.tnew = TNEW_LW;
        else              id_rec.tnew = TNEW_ALU;

        tuse_rs = (id_b_type || id_jr) ? TUSE_ID : TUSE_EX;
        if (id_b_type)     tuse_rt = TUSE_ID;
        else if (id_store) tuse_rt = TUSE_MEM;
        else               tuse_rt = TUSE_EX;
    end

    always_comb begin
        m_next      = e_rec;
        m_next.tnew = tnew_step(e_rec.tnew);
        w_next      = m_rec;
        w_next.tnew = tnew_step(m_rec.tnew);
    end

    hazard_stage_reg u_e (.clk(clk), .reset(reset), .bubble(stall), .d(id_rec), .q(e_rec));
    hazard_stage_reg u_m (.clk(clk), .reset(reset), .bubble(1'b0),  .d(m_next), .q(m_rec));
    hazard_stage_reg u_w (.clk(clk), .reset(reset), .bubble(1'b0),  .d(w_next), .q(w_rec));

    function automatic logic src_stalls(input logic [4:0] s, input logic [1:0] tuse,
                                        input stage_rec_t e, input stage_rec_t m);
        return (producer_match(e, s) && (e.tnew > tuse)) ||
               (producer_match(m, s) && (m.tnew > tuse));
    endfunction

    function automatic logic [1:0] sel_id(input logic [4:0] s,
                                          input stage_rec_t e, input stage_rec_t m);
        if (producer_match(e, s) && (e.tnew == 2'd0))      return FWD_E;
        else if (producer_match(m, s) && (m.tnew == 2'd0)) return FWD_M;
        else                                               return FWD_GRF;
    endfunction

    function automatic logic [1:0] sel_ex(input logic [4:0] s,
                                          input stage_rec_t m, input stage_rec_t w);
        if (producer_match(m, s) && (m.tnew == 2'd0))      return FWD_EX_M;
        else if (producer_match(w, s) && (w.tnew == 2'd0)) return FWD_W;
        else                                               return FWD_REG;
    endfunction

    always_comb begin
        stall      = src_stalls(id_rs, tuse_rs, e_rec, m_rec) ||
                     src_stalls(id_rt, tuse_rt, e_rec, m_rec);
        fwd_id_rs  = sel_id(id_rs, e_rec, m_rec);
        fwd_id_rt  = sel_id(id_rt, e_rec, m_rec);
        fwd_ex_rs  = sel_ex(e_rec.rs, m_rec, w_rec);
        fwd_ex_rt  = sel_ex(e_rec.rt, m_rec, w_rec);
        fwd_mem_rt = m_rec.store && producer_match(w_rec, m_rec.rt);
    end

    // Performance counter: saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign unused_bits = ^{m_rec.rs, w_rec.rs, w_rec.rt, w_rec.store};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction pairs with
// hand-computed stall/forward/count expectations.
module tb_hazard_ctrl;
    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_we, id_lw, id_link, id_b_type, id_jr, id_store;

    logic        stall, fwd_mem_rt;
    logic [1:0]  fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;
    logic [31:0] stall_cnt;

    logic        s_stall, s_fwd_mem_rt;
    logic [1:0]  s_fwd_id_rs, s_fwd_id_rt, s_fwd_ex_rs, s_fwd_ex_rt;
    logic [1:0]  s_stall_cnt;

    typedef struct packed {
        logic [4:0] rs, rt, dst;
        logic       we, lw, link, b, jr, store;
    } id_t;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  id_rs, id_rt, ex_rs, ex_rt;
        logic        mem_rt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_we(id_we), .id_lw(id_lw),
        .id_link(id_link), .id_b_type(id_b_type), .id_jr(id_jr), .id_store(id_store),
        .stall(stall), .fwd_id_rs(fwd_id_rs), .fwd_id_rt(fwd_id_rt),
        .fwd_ex_rs(fwd_ex_rs), .fwd_ex_rt(fwd_ex_rt), .fwd_mem_rt(fwd_mem_rt),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance shares stimulus to exercise saturation.
    hazard_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_we(id_we), .id_lw(id_lw),
        .id_link(id_link), .id_b_type(id_b_type), .id_jr(id_jr), .id_store(id_store),
        .stall(s_stall), .fwd_id_rs(s_fwd_id_rs), .fwd_id_rt(s_fwd_id_rt),
        .fwd_ex_rs(s_fwd_ex_rs), .fwd_ex_rt(s_fwd_ex_rt), .fwd_mem_rt(s_fwd_mem_rt),
        .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_t f_nop();
        return '0;
    endfunction
    function automatic id_t f_lw(input logic [4:0] d);
        id_t i = '0; i.dst = d; i.we = 1'b1; i.lw = 1'b1; return i;
    endfunction
    function automatic id_t f_addu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        id_t i = '0; i.dst = d; i.rs = s; i.rt = t; i.we = 1'b1; return i;
    endfunction
    function automatic id_t f_beq(input logic [4:0] s, input logic [4:0] t);
        id_t i = '0; i.rs = s; i.rt = t; i.b = 1'b1; return i;
    endfunction
    function automatic id_t f_jal();
        id_t i = '0; i.dst = 5'd31; i.we = 1'b1; i.link = 1'b1; return i;
    endfunction
    function automatic id_t f_jr(input logic [4:0] s);
        id_t i = '0; i.rs = s; i.jr = 1'b1; return i;
    endfunction
    function automatic id_t f_sw(input logic [4:0] t);
        id_t i = '0; i.rt = t; i.store = 1'b1; return i;
    endfunction

    task automatic applyStimulus(input string name, input id_t i, input logic rst_v,
                                 input logic st, input logic [1:0] irs, input logic [1:0] irt,
                                 input logic [1:0] ers, input logic [1:0] ert,
                                 input logic mrt, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        id_rs = i.rs; id_rt = i.rt; id_dst = i.dst; id_we = i.we; id_lw = i.lw;
        id_link = i.link; id_b_type = i.b; id_jr = i.jr; id_store = i.store;
        reset = rst_v;
        e.name = name; e.stall = st; e.id_rs = irs; e.id_rt = irt;
        e.ex_rs = ers; e.ex_rt = ert; e.mem_rt = mrt; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [1:0] exp_small;
        exp_small = (e.cnt > 32'd3) ? 2'd3 : e.cnt[1:0];
        vectors_applied++;
        if (stall !== e.stall || fwd_id_rs !== e.id_rs || fwd_id_rt !== e.id_rt ||
            fwd_ex_rs !== e.ex_rs || fwd_ex_rt !== e.ex_rt || fwd_mem_rt !== e.mem_rt ||
            stall_cnt !== e.cnt || s_stall_cnt !== exp_small) begin
            miscompares++;
            $display("[TB] FAIL %s: got stall=%0d id=%0d/%0d ex=%0d/%0d mem=%0d cnt=%0d cnt2=%0d, expected stall=%0d id=%0d/%0d ex=%0d/%0d mem=%0d cnt=%0d cnt2=%0d",
                     e.name, stall, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt, fwd_mem_rt,
                     stall_cnt, s_stall_cnt, e.stall, e.id_rs, e.id_rt, e.ex_rs, e.ex_rt,
                     e.mem_rt, e.cnt, exp_small);
        end
    endtask

    // Monitor: outputs are presented every cycle; sample mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {id_rs, id_rt, id_dst, id_we, id_lw, id_link, id_b_type, id_jr, id_store} = '0;

        applyStimulus("reset",      f_nop(),               1, 0, 0, 0, 0, 0, 0, 0);
        // lw $1 ; addu $2,$1,$3
        applyStimulus("t1_lw",      f_lw(1),               0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("t1_stall",   f_addu(2, 1, 3),       0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("t1_release", f_addu(2, 1, 3),       0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("t1_ex_fwdW", f_nop(),               0, 0, 0, 0, 2, 0, 0, 1);
        applyStimulus("t1_drain1",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("t1_drain2",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 1);
        // lw $1 ; beq $1,$2
        applyStimulus("t2_lw",      f_lw(1),               0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("t2_stall1",  f_beq(1, 2),           0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus("t2_stall2",  f_beq(1, 2),           0, 1, 0, 0, 0, 0, 0, 2);
        applyStimulus("t2_grf",     f_beq(1, 2),           0, 0, 0, 0, 0, 0, 0, 3);
        applyStimulus("t2_drain1",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 3);
        applyStimulus("t2_drain2",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 3);
        applyStimulus("t2_drain3",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 3);
        // addu $1,$2,$3 ; beq $1,$0
        applyStimulus("t3_addu",    f_addu(1, 2, 3),       0, 0, 0, 0, 0, 0, 0, 3);
        applyStimulus("t3_stall",   f_beq(1, 0),           0, 1, 0, 0, 0, 0, 0, 3);
        applyStimulus("t3_id_fwdM", f_beq(1, 0),           0, 0, 2, 0, 0, 0, 0, 4);
        applyStimulus("t3_ex_fwdW", f_nop(),               0, 0, 0, 0, 2, 0, 0, 4);
        applyStimulus("t3_drain1",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t3_drain2",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        // jal ; jr $31
        applyStimulus("t4_jal",     f_jal(),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t4_id_fwdE", f_jr(31),              0, 0, 1, 0, 0, 0, 0, 4);
        applyStimulus("t4_ex_fwdM", f_nop(),               0, 0, 0, 0, 1, 0, 0, 4);
        applyStimulus("t4_drain1",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t4_drain2",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        // addu $0,$1,$2 ; addu $3,$0,$0
        applyStimulus("t5_wr_zero", f_addu(0, 1, 2),       0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t5_rd_zero", f_addu(3, 0, 0),       0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t5_drain1",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t5_drain2",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t5_drain3",  f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        // lw $1 ; sw $1,4($0)
        applyStimulus("t6_lw",      f_lw(1),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t6_sw",      f_sw(1),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t6_ex",      f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t6_mem_fwd", f_nop(),               0, 0, 0, 0, 0, 0, 1, 4);
        applyStimulus("t6_drain",   f_nop(),               0, 0, 0, 0, 0, 0, 0, 4);
        // reset asserted while a lw-beq stall is pending
        applyStimulus("t7_lw",      f_lw(1),               0, 0, 0, 0, 0, 0, 0, 4);
        applyStimulus("t7_stall",   f_beq(1, 2),           0, 1, 0, 0, 0, 0, 0, 4);
        applyStimulus("t7_rst_mid", f_beq(1, 2),           1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("t7_after",   f_beq(1, 2),           0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("t7_drain",   f_nop(),               0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID-stage decoder and tracks register-writing instructions in flight through E/M/W.
- Stalls IF/ID and injects an E-stage bubble on load-use or branch-use hazards that forwarding cannot cover.
- Drives forwarding selects for ID-stage compare operands, EX ALU operands and the MEM store-data operand.
- Keeps a saturating stall counter for performance debugging.

Parameters:
CNT_W, 32, width of stall_cnt (saturates at all-ones)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of instruction in ID (0 if unused)
id_rt  in  5  rt field of instruction in ID (0 if unused)
id_dst  in  5  destination GRF index of ID instruction (31 for jal)
id_we  in  1  ID instruction writes GRF
id_lw  in  1  ID instruction is lw
id_link  in  1  ID instruction is jal (result PC+8 known in E)
id_b_type  in  1  ID instruction is beq (rs, rt compared in ID)
id_jr  in  1  ID instruction is jr (rs used in ID)
id_store  in  1  ID instruction is sw (rt used in MEM)
stall  out  1  hold PC and IF/ID; bubble into ID/EX
fwd_id_rs  out  2  ID rs compare operand: 0 GRF, 1 E (link value), 2 M result
fwd_id_rt  out  2  same encoding, for rt
fwd_ex_rs  out  2  EX rs operand: 0 ID/EX reg, 1 M result, 2 W result
fwd_ex_rt  out  2  same encoding, for rt
fwd_mem_rt  out  1  MEM store data: 0 EX/MEM reg, 1 W result
stall_cnt  out  CNT_W  cycles with stall=1 since reset

Behaviour:
- Reset: all stage records cleared (we=0, dst=0, tnew=0, rs=rt=0). All outputs are 0 while reset is high and right after it. stall_cnt is 0.
- Stage records E, M, W each hold dst, we, tnew[1:0], rs, rt, store. They update on posedge clk.
- Tnew on entry to E: link=0, lw=2, other we=1 instructions=1, we=0 instructions=0.
- On each advance, tnew decrements, saturating at 0.
- Tuse for rs: 0 if b_type or jr, else 1.
- Tuse for rt: 0 if b_type, 2 if store, else 1.
- A source with index 0 never creates a hazard or a forward. A stage with we=0 or dst=0 is never a producer.
- stall is combinational. It is 1 iff, for any ID source s with a nonzero index, either:
  - E.we and E.dst==s and E.tnew > tuse(s), or
  - M.we and M.dst==s and M.tnew > tuse(s).
- stall=1: E loads a bubble (all zero), M<=E, W<=M. The ID inputs are presented again next cycle.
- stall=0: E<=ID-derived record, M<=E, W<=M. There is no backpressure from later stages.
- Forward priority is the youngest producer first.
  - fwd_id_*: E with match and tnew==0, else M with match and tnew==0, else 0.
  - fwd_ex_*: compares the E record's rs/rt. M with match and tnew==0, else W with match, else 0.
  - fwd_mem_rt: the M record's rt with store=1 matched against W, else 0.
- W-to-ID is not forwarded; the GRF is write-before-read.
- Forward selects are combinational and valid in the same cycle as stall. When stall=1, fwd_id_* are don't-care but still follow the rules above.
- stall_cnt increments when stall=1 at a clock edge and holds at 2^CNT_W-1.
- Reset mid-stall: records clear asynchronously, so stall falls in the same cycle reset rises.

Decomposition:
- Shared package: stage-record struct, and the Tuse/Tnew constants (TUSE_ID=0, TUSE_EX=1, TUSE_MEM=2, TNEW_LW=2, TNEW_ALU=1, TNEW_LINK=0).
- Shared package: forward-select encodings (FWD_GRF, FWD_E, FWD_M, FWD_W).
- One natural sub-module: hazard_stage_reg, holding one stage record with bubble/load/async clear. It is instantiated three times.

Test Plan:
1. lw $1,0($0) then addu $2,$1,$3:
   - stall=1 for exactly 1 cycle.
   - Next cycle addu enters E with fwd_ex_rs=2 (W).
   - stall_cnt=1.
2. lw $1 then beq $1,$2:
   - stall=1 for 2 consecutive cycles.
   - Then fwd_id_rs=0 (value arrives through the GRF from W).
   - stall_cnt=2.
3. addu $1,$2,$3 then beq $1,$0:
   - 1 stall cycle.
   - Then fwd_id_rs=2 (M). fwd_id_rt=0 (index 0).
4. jal then jr $31 in the delay slot:
   - stall=0.
   - fwd_id_rs=1 (E link value).
5. addu $0,$1,$2 then addu $3,$0,$0:
   - stall=0.
   - All fwd_* stay 0.
6. lw $1 then sw $1,4($0):
   - stall=0.
   - Two cycles later fwd_mem_rt=1.
   - Separately, assert reset while a lw-beq stall is active: stall, all fwd_* and stall_cnt read 0 immediately.
